// File: rtl/diff_pkg.sv
// Shared types for the difference/integrator datapath: default widths,
// sample/accumulator typedefs and a saturating add for the default accumulator width.
package diff_pkg;

  localparam int DEFAULT_IN_W  = 8;
  localparam int DEFAULT_ACC_W = 16;

  typedef logic signed [DEFAULT_IN_W-1:0]  sample_t;
  typedef logic signed [DEFAULT_ACC_W-1:0] acc_t;

  typedef struct packed {
    acc_t sum;
    logic clip;
  } sat_sum_t;

  // One guard bit exposes overflow; on overflow the sum pins to the rail
  // that matches the sign of the true result.
  function automatic sat_sum_t sat_add(acc_t a, acc_t b);
    logic signed [DEFAULT_ACC_W:0] wide;
    sat_sum_t res;
    wide = {a[DEFAULT_ACC_W-1], a} + {b[DEFAULT_ACC_W-1], b};
    if (wide[DEFAULT_ACC_W] != wide[DEFAULT_ACC_W-1]) begin
      res.clip = 1'b1;
      res.sum  = wide[DEFAULT_ACC_W] ? {1'b1, {(DEFAULT_ACC_W-1){1'b0}}}
                                     : {1'b0, {(DEFAULT_ACC_W-1){1'b1}}};
    end else begin
      res.clip = 1'b0;
      res.sum  = wide[DEFAULT_ACC_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/diff_out_buf.sv
// One-entry valid/ready holding register for the window sum and its clip flag.
module diff_out_buf #(
  parameter int W = 16
) (
  input  logic         clk_80,
  input  logic         rst_80,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_sat,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  output logic         out_sat
);

  logic [W-1:0] data_reg;
  logic         valid_reg;
  logic         sat_reg;

  // A load in the same cycle as a pop wins, so back-to-back sums never bubble.
  always_ff @(posedge clk_80 or posedge rst_80) begin
    if (rst_80) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
      sat_reg   <= 1'b0;
    end else if (load) begin
      data_reg  <= load_data;
      valid_reg <= 1'b1;
      sat_reg   <= load_sat;
    end else if (valid_reg && out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_data  = data_reg;
  assign out_valid = valid_reg;
  assign out_sat   = sat_reg;

endmodule

// File: rtl/diff_integrator.sv
// Integrate-and-dump: sums DUMP_LEN accepted samples and hands the window sum to a
// one-entry output buffer. Define DIFF_INTEG_SAT_EN for saturating accumulation.
module diff_integrator
  import diff_pkg::*;
#(
  parameter int  IN_W     = DEFAULT_IN_W,
  parameter int  ACC_W    = DEFAULT_ACC_W,
  parameter int  DUMP_LEN = 4,
  localparam int CNT_W    = $clog2(DUMP_LEN + 1)
) (
  input  logic                    clk_80,
  input  logic                    rst_80,
  input  logic                    clr,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sat
);

  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] in_ext;
  logic [CNT_W-1:0]        cnt_reg;
  logic                    last_sample;
  logic                    accept;
  logic                    sat_next;

  assign in_ext      = ACC_W'(in_data);
  assign last_sample = (cnt_reg == CNT_W'(DUMP_LEN - 1));
  // Only the window-closing sample needs a free output slot; clr drops any offer.
  assign in_ready    = !clr && !(last_sample && out_valid && !out_ready);
  assign accept      = in_valid && in_ready;

`ifdef DIFF_INTEG_SAT_EN
  logic                    sticky_reg;
  logic signed [ACC_W:0]   wide_sum;
  logic                    step_clip;

  always_comb begin
    wide_sum  = {acc_reg[ACC_W-1], acc_reg} + {in_ext[ACC_W-1], in_ext};
    step_clip = (wide_sum[ACC_W] != wide_sum[ACC_W-1]);
    acc_next  = wide_sum[ACC_W-1:0];
    if (step_clip) begin
      acc_next = wide_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};
    end
    sat_next  = sticky_reg | step_clip;
  end

  always_ff @(posedge clk_80 or posedge rst_80) begin
    if (rst_80) begin
      sticky_reg <= 1'b0;
    end else if (clr || (accept && last_sample)) begin
      sticky_reg <= 1'b0;
    end else if (accept) begin
      sticky_reg <= sat_next;
    end
  end
`else
  assign acc_next = acc_reg + in_ext;
  assign sat_next = 1'b0;
`endif

  always_ff @(posedge clk_80 or posedge rst_80) begin
    if (rst_80) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (clr) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (accept) begin
      if (last_sample) begin
        acc_reg <= '0;
        cnt_reg <= '0;
      end else begin
        acc_reg <= acc_next;
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  diff_out_buf #(
    .W(ACC_W)
  ) u_out_buf (
    .clk_80    (clk_80),
    .rst_80    (rst_80),
    .load      (accept && last_sample),
    .load_data (acc_next),
    .load_sat  (sat_next),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sat   (out_sat)
  );

endmodule

// File: tb/tb_diff_integrator.sv
// Drives three integrator configurations from one stimulus stream and checks each
// against a window-list reference model.
module tb_diff_integrator;

  logic              clk_80 = 1'b0;
  logic              rst_80 = 1'b1;
  logic              clr = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic signed [7:0] in_data = '0;

  logic        rdy [3];
  logic        ov  [3];
  logic        os  [3];
  logic [15:0] od0;
  logic [7:0]  od1;
  logic [15:0] od2;

  always #6 clk_80 = ~clk_80;

  diff_integrator #(.IN_W(8), .ACC_W(16), .DUMP_LEN(4)) dut_w16 (
    .clk_80(clk_80), .rst_80(rst_80), .clr(clr), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[0]), .out_data(od0), .out_valid(ov[0]), .out_ready(out_ready), .out_sat(os[0]));

  diff_integrator #(.IN_W(8), .ACC_W(8), .DUMP_LEN(4)) dut_w8 (
    .clk_80(clk_80), .rst_80(rst_80), .clr(clr), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[1]), .out_data(od1), .out_valid(ov[1]), .out_ready(out_ready), .out_sat(os[1]));

  diff_integrator #(.IN_W(8), .ACC_W(16), .DUMP_LEN(1)) dut_len1 (
    .clk_80(clk_80), .rst_80(rst_80), .clr(clr), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[2]), .out_data(od2), .out_valid(ov[2]), .out_ready(out_ready), .out_sat(os[2]));

  int n_chk  = 0;
  int n_fail = 0;
  int len [3] = '{4, 4, 1};
  int wid [3] = '{16, 8, 16};
  int win_buf [3][4];
  int win_n [3];
  bit pv [3];
  int pd [3];
  bit ps [3];
  bit acc_flag [3];

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_data(input int k);
    case (k)
      0:       return {16'b0, od0};
      1:       return {24'b0, od1};
      default: return {16'b0, od2};
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      win_n[k] = 0;
      pv[k] = 1'b0;
      pd[k] = 0;
      ps[k] = 1'b0;
      acc_flag[k] = 1'b0;
    end
  endtask

  // Window sum from the stored sample list, clipping each step when saturation is built in.
  task automatic win_result(input int k, output int data, output bit sat);
    int acc;
    int mx;
    int mn;
    acc = 0;
    sat = 1'b0;
    mx = (1 << (wid[k] - 1)) - 1;
    mn = -(1 << (wid[k] - 1));
    for (int i = 0; i < win_n[k]; i++) begin
      acc += win_buf[k][i];
`ifdef DIFF_INTEG_SAT_EN
      if (acc > mx) begin acc = mx; sat = 1'b1; end
      else if (acc < mn) begin acc = mn; sat = 1'b1; end
`endif
    end
    data = acc & ((1 << wid[k]) - 1);
  endtask

  // Check outputs mid-cycle, advance the model to what the next rising edge produces.
  task automatic cycle();
    bit erdy;
    int d;
    bit s;
    @(negedge clk_80);
    for (int k = 0; k < 3; k++) begin
      erdy = !clr && !((win_n[k] == len[k] - 1) && pv[k] && !out_ready);
      chk("in_ready", k, {31'b0, rdy[k]}, {31'b0, erdy});
      chk("out_valid", k, {31'b0, ov[k]}, {31'b0, pv[k]});
      if (pv[k]) begin
        chk("out_data", k, obs_data(k), pd[k]);
        chk("out_sat", k, {31'b0, os[k]}, {31'b0, ps[k]});
      end
      acc_flag[k] = in_valid && erdy;
      if (pv[k] && out_ready) pv[k] = 1'b0;
      if (clr) begin
        win_n[k] = 0;
      end else if (acc_flag[k]) begin
        win_buf[k][win_n[k]] = int'(in_data);
        win_n[k]++;
        if (win_n[k] == len[k]) begin
          win_result(k, d, s);
          pv[k] = 1'b1;
          pd[k] = d;
          ps[k] = s;
          win_n[k] = 0;
        end
      end
    end
    @(posedge clk_80);
    #1;
  endtask

  // Offer one sample until the 16-bit instance takes it, within a cycle budget.
  task automatic send(input int v);
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    in_data = 8'(v);
    for (int t = 0; t < 20 && !got; t++) begin
      cycle();
      got = acc_flag[0];
    end
    in_valid = 1'b0;
    chk("send_accept", 0, {31'b0, got}, 32'd1);
  endtask

  logic [7:0] exp_d8;
  logic       exp_s8;

  initial begin
    model_reset();
    repeat (2) @(posedge clk_80);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_valid", k, {31'b0, ov[k]}, 32'd0);
      chk("reset_data", k, obs_data(k), 32'd0);
      chk("reset_sat", k, {31'b0, os[k]}, 32'd0);
      chk("reset_ready", k, {31'b0, rdy[k]}, 32'd1);
    end
    rst_80 = 1'b0;
    out_ready = 1'b1;

    // 1..4 back to back: sum 10 for exactly one cycle
    send(1); send(2); send(3); send(4);
    chk("sum_10", 0, {16'b0, od0}, 32'd10);
    chk("sum_10_valid", 0, {31'b0, ov[0]}, 32'd1);
    cycle();
    chk("pulse_1cyc", 0, {31'b0, ov[0]}, 32'd0);

    // all most-negative samples
    send(-128); send(-128); send(-128); send(-128);
    chk("neg_sum", 0, {16'b0, od0}, 32'h0000FE00);

    // narrow accumulator overflow
`ifdef DIFF_INTEG_SAT_EN
    exp_d8 = 8'd127; exp_s8 = 1'b1;
`else
    exp_d8 = 8'hC8;  exp_s8 = 1'b0;
`endif
    send(100); send(100); send(0); send(0);
    chk("w8_data", 1, {24'b0, od1}, {24'b0, exp_d8});
    chk("w8_sat", 1, {31'b0, os[1]}, {31'b0, exp_s8});
    chk("w16_200", 0, {16'b0, od0}, 32'd200);
    cycle();

    // backpressure: non-final samples flow, final one stalls
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(1);
    in_valid = 1'b1;
    in_data = 8'sd1;
    repeat (3) cycle();
    chk("stall_ready", 0, {31'b0, rdy[0]}, 32'd0);
    chk("stall_held", 0, {16'b0, od0}, 32'd4);
    out_ready = 1'b1;
    send(1);
    chk("second_sum", 0, {16'b0, od0}, 32'd4);
    chk("second_valid", 0, {31'b0, ov[0]}, 32'd1);
    cycle();

    // asynchronous reset in the middle of a window with a pending sum
    out_ready = 1'b0;
    send(5); send(5);
    #3 rst_80 = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("arst_valid", k, {31'b0, ov[k]}, 32'd0);
      chk("arst_data", k, obs_data(k), 32'd0);
    end
    model_reset();
    @(posedge clk_80);
    #1 rst_80 = 1'b0;
    out_ready = 1'b1;
    send(1); send(1); send(1); send(1);
    chk("post_reset_sum", 0, {16'b0, od0}, 32'd4);
    cycle();

    // clr with a pending sum and an offered sample
    out_ready = 1'b0;
    send(1); send(2); send(3); send(4);
    send(7);
    clr = 1'b1;
    in_valid = 1'b1;
    in_data = 8'sd9;
    cycle();
    clr = 1'b0;
    in_valid = 1'b0;
    chk("clr_keeps_data", 0, {16'b0, od0}, 32'd10);
    chk("clr_keeps_valid", 0, {31'b0, ov[0]}, 32'd1);
    out_ready = 1'b1;
    cycle();
    send(1); send(1); send(1); send(1);
    chk("clr_restart", 0, {16'b0, od0}, 32'd4);
    cycle();

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      clr       = ($urandom_range(0, 31) == 0);
      cycle();
    end
    clr = 1'b0;
    in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/diff_integrator.md
Name: diff_integrator

Overview:
Streaming integrate-and-dump block, the inverse stage of the first-difference (differentiator) datapath. It accepts signed samples over a valid/ready handshake and accumulates DUMP_LEN consecutive samples. It then emits the block sum on a valid/ready output through a one-entry output buffer and restarts the accumulation from zero. It sits directly downstream of the difference stage to reconstruct windowed sums.

Parameters:
IN_W, 8, signed input sample width
ACC_W, 16, signed accumulator/output width; legal range ACC_W >= IN_W
DUMP_LEN, 4, samples per dump window; legal range DUMP_LEN >= 1
CNT_W, $clog2(DUMP_LEN+1), sample counter width (derived, not overridden)

Ports:
clk_80  in  1  clock, all state on rising edge
rst_80  in  1  reset, asynchronous, active-high
clr  in  1  synchronous clear of accumulator and counter
in_data  in  IN_W  signed input sample
in_valid  in  1  input sample present
in_ready  out  1  block can accept sample this cycle
out_data  out  ACC_W  signed window sum
out_valid  out  1  out_data holds an undelivered sum
out_ready  in  1  consumer accepts out_data
out_sat  out  1  window sum clipped; constant 0 when feature compiled out

Behaviour:
- Reset (rst_80 high, asynchronous): acc=0, cnt=0, out_data=0, out_valid=0, out_sat=0. in_ready is combinational and reads 1 while out_valid=0.
- Sample accept: in_valid && in_ready at a rising edge. in_data is sign-extended to ACC_W and added to acc.
- Arithmetic: acc_next = acc + sext(in_data), two's-complement, ACC_W bits, wrap on overflow (unless the feature below is enabled).
- Counter: cnt increments on each accept. On the accept with cnt == DUMP_LEN-1 (the "final sample"):
  - out_data <= acc + sext(in_data)
  - out_valid <= 1
  - acc <= 0, cnt <= 0
- Latency: the sum is visible on out_data/out_valid the cycle after the final sample is accepted.
- Output hold: out_data and out_valid stay stable while out_valid && !out_ready. out_valid clears on out_valid && out_ready unless a new final sample loads in the same cycle, in which case out_valid stays 1 with the new data.
- in_ready = !(cnt == DUMP_LEN-1 && out_valid && !out_ready).
  - Non-final samples are always accepted, so accumulation continues under output backpressure.
  - Only the final sample stalls.
- DUMP_LEN == 1: every sample is a final sample; the block degenerates to a registered, width-extending pass-through with a skid of one.
- clr: acc=0 and cnt=0 next cycle. Any sample offered that cycle is dropped: in_ready is forced 0 while clr is high. The output buffer (out_data/out_valid) is unaffected so a pending sum is not lost.
- rst_80 mid-window: partial sum discarded, pending output discarded, all values return to reset values immediately.
- No internal state beyond acc, cnt, out_data, out_valid, out_sat.

Optional Feature:
DIFF_INTEG_SAT_EN
- Defined:
  - Each accumulation step saturates to [-(2^(ACC_W-1)), 2^(ACC_W-1)-1]; once saturated, later samples keep adding from the clipped value.
  - A window-local sticky flag records any clip. It is copied to out_sat with out_data and cleared with acc at window end, clr, or reset.
- Undefined: plain wrap arithmetic; out_sat tied 0.

Decomposition:
- Shared package diff_pkg:
  - IN_W/ACC_W default constants
  - typedefs for sample_t and acc_t
  - function sat_add(acc_t a, acc_t b) returning sum and clip bit
- One natural sub-module: diff_out_buf, the one-entry valid/ready output holding register (data + sat bit, async reset on rst_80).
- The accumulator, counter and in_ready logic stay in the top.

Test Plan:
- DUMP_LEN=4, ACC_W=16, in 1,2,3,4 back-to-back, out_ready=1 -> out_data=10, out_valid for 1 cycle, one cycle after the 4th accept; next window starts at 0.
- Negative: in -128,-128,-128,-128 -> out_data=-512 (16'hFE00).
- ACC_W=8, DUMP_LEN=4, in 100,100,0,0 -> macro off: out_data=-56, out_sat=0; macro on: out_data=127, out_sat=1.
- Backpressure: out_ready=0 after first sum, stream 8 samples of 1 -> samples 5-7 accepted, in_ready=0 on 8th until out_ready=1; sums 4 then 4, none lost or duplicated.
- Reset mid-window: accept 5,5, assert rst_80 asynchronously between edges -> out_valid=0, out_data=0 immediately; next full window 1,1,1,1 -> 4.
- clr with pending output: sum 10 pending, out_ready=0, pulse clr with in_valid=1 -> in_ready=0 that cycle, out_data stays 10, acc and cnt restart at 0.
